teclado: RTL and testbench

TECLADO -- requirements
Module: teclado

---
 rtl/teclado_pkg.sv | 33 +++
 rtl/teclado_if.sv | 14 +
 rtl/teclado_sincronizador.sv | 31 +++
 rtl/teclado.sv | 182 ++++++++++++++++++
 tb/tb_teclado.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/teclado_pkg.sv
// teclado_pkg: shared definitions for the keypad scanner.
//   COD_W         width of the key code sent downstream (row:col, 2+2 bits)
//   LINHA_OCIOSA  row pattern driven at reset (row 1 low)
//   estado_t      scanner FSM states
//   coluna_baixa  index (0..3) of the lowest low column of a sense vector
//   linha_onehot  active-low one-hot row drive for a row index (0..3)
package teclado_pkg;

    localparam int unsigned COD_W = 4;
    localparam logic [3:0] LINHA_OCIOSA = 4'b1110;

    typedef enum logic [1:0] {
        VARRE,
        DEBOUNCE,
        EMITE,
        ESPERA_SOLTA
    } estado_t;

    // Lowest column index wins when several columns are low.
    function automatic logic [1:0] coluna_baixa(input logic [3:0] c);
        logic [1:0] r;
        if (!c[0])      r = 2'd0;
        else if (!c[1]) r = 2'd1;
        else if (!c[2]) r = 2'd2;
        else            r = 2'd3;
        return r;
    endfunction

    function automatic logic [3:0] linha_onehot(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/teclado_if.sv
// teclado_if: key code bus from the keypad scanner to the downstream machine.
//   numero  code of the last accepted key {row-1, col-1}
//   insere  one-cycle pulse flagging a new code on numero
//   master  driven by teclado; slave  consumed by the downstream block
interface teclado_if;
    import teclado_pkg::*;

    logic [COD_W:1] numero;
    logic           insere;

    modport master (output numero, output insere);
    modport slave  (input  numero, input  insere);

endinterface

// File: rtl/teclado_sincronizador.sv
// sincronizador: two-stage synchronizer for asynchronous level inputs.
//   clk    sampling clock
//   rst_n  asynchronous active-low reset; both stages reset to all-ones
//          (idle level of pulled-up lines)
//   d_i    asynchronous input vector
//   q_o    synchronized output vector
module sincronizador #(
    parameter int unsigned LARGURA = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] d_i,
    output logic [LARGURA-1:0] q_o
);

    logic [LARGURA-1:0] meta_q;
    logic [LARGURA-1:0] sinc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sinc_q <= '1;
        end else begin
            meta_q <= d_i;
            sinc_q <= meta_q;
        end
    end

    assign q_o = sinc_q;

endmodule

// File: rtl/teclado.sv
// teclado: 4x4 matrix keypad scanner with debounce.
//   clk     single clock, rising edge
//   reset   asynchronous active-low reset
//   coluna  column sense lines, active-low, asynchronous
//   linha   row drive, one-hot active-low
//   saida   key code bus (numero, insere) to the downstream machine
// Build option: define TECLADO_REPEAT_EN to emit an extra insere every
// REPEAT_CICLOS cycles while the key stays held.
module teclado
    import teclado_pkg::*;
#(
    parameter int unsigned SCAN_CICLOS     = 2,
    parameter int unsigned DEBOUNCE_CICLOS = 4,
    parameter int unsigned REPEAT_CICLOS   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:1]    coluna,
    output logic [4:1]    linha,
    teclado_if.master     saida
);

    localparam int unsigned SW = (SCAN_CICLOS > 1) ? $clog2(SCAN_CICLOS) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CICLOS + 1);

    if (SCAN_CICLOS < 2 || DEBOUNCE_CICLOS < 1 || REPEAT_CICLOS < 1) begin : g_param_invalido
        $error("teclado: parameter out of range");
    end

    logic [3:0]     colsync;
    estado_t        estado_q;
    logic [1:0]     idx_q;
    logic [3:0]     linha_q;
    logic [SW-1:0]  scan_cnt_q;
    logic [DW-1:0]  deb_cnt_q;
    logic [1:0]     col_q;
    logic [COD_W:1] numero_q;
    logic           insere_q;

    // Row index that was driven when the current colsync value was sampled.
    logic [1:0]     idx_p1_q;
    logic [1:0]     idx_p2_q;
    logic           val_p1_q;
    logic           val_p2_q;

    logic           alinhada;
    logic           col_alta;

`ifdef TECLADO_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CICLOS + 1);
    logic [RW-1:0]  rep_cnt_q;
`endif

    sincronizador #(
        .LARGURA (4)
    ) u_sinc (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (coluna),
        .q_o   (colsync)
    );

    // colsync lags linha by the synchronizer depth. A sample is only
    // attributed to a row when the delayed row index matches; during
    // DEBOUNCE/ESPERA_SOLTA this discards the stale samples taken while a
    // different row was still driven.
    assign alinhada = val_p2_q && (idx_p2_q == idx_q);
    assign col_alta = colsync[col_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= VARRE;
            idx_q      <= 2'd0;
            linha_q    <= LINHA_OCIOSA;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            col_q      <= 2'd0;
            numero_q   <= '0;
            insere_q   <= 1'b0;
            idx_p1_q   <= 2'd0;
            idx_p2_q   <= 2'd0;
            val_p1_q   <= 1'b0;
            val_p2_q   <= 1'b0;
`ifdef TECLADO_REPEAT_EN
            rep_cnt_q  <= '0;
`endif
        end else begin
            insere_q <= 1'b0;
            idx_p1_q <= idx_q;
            idx_p2_q <= idx_p1_q;
            val_p1_q <= 1'b1;
            val_p2_q <= val_p1_q;

            case (estado_q)
                VARRE: begin
                    if (scan_cnt_q == SW'(SCAN_CICLOS - 1)) begin
                        scan_cnt_q <= '0;
                        if (val_p2_q && (colsync != 4'b1111)) begin
                            // Latch the row the sample belongs to, which
                            // may be the previous slot for short slots.
                            idx_q     <= idx_p2_q;
                            linha_q   <= linha_onehot(idx_p2_q);
                            col_q     <= coluna_baixa(colsync);
                            deb_cnt_q <= '0;
                            estado_q  <= DEBOUNCE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            linha_q <= linha_onehot(idx_q + 2'd1);
                        end
                    end else begin
                        scan_cnt_q <= scan_cnt_q + SW'(1);
                    end
                end

                DEBOUNCE: begin
                    if (alinhada) begin
                        if (!col_alta) begin
                            if (deb_cnt_q == DW'(DEBOUNCE_CICLOS - 1)) begin
                                deb_cnt_q <= '0;
                                estado_q  <= EMITE;
                            end else begin
                                deb_cnt_q <= deb_cnt_q + DW'(1);
                            end
                        end else begin
                            deb_cnt_q  <= '0;
                            scan_cnt_q <= '0;
                            idx_q      <= idx_q + 2'd1;
                            linha_q    <= linha_onehot(idx_q + 2'd1);
                            estado_q   <= VARRE;
                        end
                    end
                end

                EMITE: begin
                    numero_q  <= {idx_q, col_q};
                    insere_q  <= 1'b1;
                    deb_cnt_q <= '0;
`ifdef TECLADO_REPEAT_EN
                    rep_cnt_q <= '0;
`endif
                    estado_q  <= ESPERA_SOLTA;
                end

                ESPERA_SOLTA: begin
                    if (alinhada) begin
                        if (col_alta) begin
`ifdef TECLADO_REPEAT_EN
                            rep_cnt_q <= '0;
`endif
                            if (deb_cnt_q == DW'(DEBOUNCE_CICLOS - 1)) begin
                                deb_cnt_q  <= '0;
                                scan_cnt_q <= '0;
                                idx_q      <= idx_q + 2'd1;
                                linha_q    <= linha_onehot(idx_q + 2'd1);
                                estado_q   <= VARRE;
                            end else begin
                                deb_cnt_q <= deb_cnt_q + DW'(1);
                            end
                        end else begin
                            deb_cnt_q <= '0;
`ifdef TECLADO_REPEAT_EN
                            if (rep_cnt_q == RW'(REPEAT_CICLOS - 1)) begin
                                rep_cnt_q <= '0;
                                insere_q  <= 1'b1;
                            end else begin
                                rep_cnt_q <= rep_cnt_q + RW'(1);
                            end
`endif
                        end
                    end
                end

                default: estado_q <= VARRE;
            endcase
        end
    end

    assign linha        = linha_q;
    assign saida.numero = numero_q;
    assign saida.insere = insere_q;

endmodule

// File: tb/tb_teclado.sv
// tb_teclado: directed bench for teclado with a behavioural keypad model.
module tb_teclado;

    localparam int unsigned SCAN = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned REP  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:1] coluna;
    logic [4:1] linha;

    teclado_if bus ();

    teclado #(
        .SCAN_CICLOS     (SCAN),
        .DEBOUNCE_CICLOS (DEB),
        .REPEAT_CICLOS   (REP)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .coluna (coluna),
        .linha  (linha),
        .saida  (bus)
    );

    always #5 clk = ~clk;

    // Keypad: pressed columns pull low only while their row is driven.
    logic       tecla_on;
    logic [4:1] tecla_linha;
    logic [4:1] tecla_cols;

    always_comb begin
        coluna = 4'b1111;
        if (tecla_on && (linha == tecla_linha))
            coluna = ~tecla_cols;
    end

    int n_ok  = 0;
    int n_tot = 0;
    int n_pulsos = 0;
    logic [4:1] ult_num = 4'b0000;

    always @(negedge clk) begin
        if (bus.insere === 1'b1) begin
            n_pulsos = n_pulsos + 1;
            ult_num  = bus.numero;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs === exp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic espera(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic aperta(input logic [4:1] lin, input logic [4:1] cols);
        tecla_linha = lin;
        tecla_cols  = cols;
        tecla_on    = 1'b1;
    endtask

    task automatic solta();
        tecla_on = 1'b0;
    endtask

    task automatic espera_pulso(input int base, input int limite, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limite; i++) begin
            @(negedge clk);
            if (n_pulsos > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    int   base;
    bit   ok;
    logic [4:1] num1;
    int   seguidos;

    initial begin
        reset       = 1'b0;
        tecla_on    = 1'b0;
        tecla_linha = 4'b1111;
        tecla_cols  = 4'b0000;

        // Reset state
        espera(3);
        check("rst_linha",  linha, 4'b1110);
        check("rst_numero", bus.numero, 4'b0000);
        check("rst_insere", bus.insere, 1'b0);

        // Two-cycle glitch on row 1 / column 1 while row 1 is driven
        reset = 1'b1;
        aperta(4'b1110, 4'b0001);
        espera(2);
        solta();
        espera(30);
        check("glitch_pulsos", n_pulsos, 0);
        check("glitch_numero", bus.numero, 4'b0000);

        // Row 2 / column 3 held 40 cycles
        base = n_pulsos;
        aperta(4'b1101, 4'b0100);
        espera(40);
        check("r2c3_pulsos", n_pulsos - base, 1);
        check("r2c3_numero", ult_num, 4'b0110);
        solta();
        espera(20);
        check("r2c3_solta", n_pulsos - base, 1);
        check("r2c3_hold",  bus.numero, 4'b0110);

        // Row 3, columns 1 and 4 together
        base = n_pulsos;
        aperta(4'b1011, 4'b1001);
        espera(40);
        check("r3c14_pulsos", n_pulsos - base, 1);
        check("r3c14_numero", ult_num, 4'b1000);
        solta();
        espera(20);

        // Same key twice with a full release in between
        base = n_pulsos;
        aperta(4'b1110, 4'b0010);
        espera(40);
        num1 = ult_num;
        solta();
        espera(20);
        aperta(4'b1110, 4'b0010);
        espera(40);
        check("dupla_pulsos", n_pulsos - base, 2);
        check("dupla_num1",   num1, 4'b0001);
        check("dupla_num2",   ult_num, 4'b0001);
        solta();
        espera(20);

        // Row 4 / column 4 held 3*REP cycles past acceptance
        base = n_pulsos;
        aperta(4'b0111, 4'b1000);
        espera_pulso(base, 40, ok);
        check("r4c4_aceita", ok, 1'b1);
        espera(3 * REP + 4);
        solta();
        espera(20);
`ifdef TECLADO_REPEAT_EN
        check("r4c4_pulsos", n_pulsos - base, 4);
`else
        check("r4c4_pulsos", n_pulsos - base, 1);
`endif
        check("r4c4_numero", ult_num, 4'b1111);

        // Reset during DEBOUNCE: row 1 held from reset release, row 1
        // observed driven for 3 consecutive cycles means scanning stopped.
        reset = 1'b0;
        espera(2);
        aperta(4'b1110, 4'b0010);
        base = n_pulsos;
        reset = 1'b1;
        ok = 1'b0;
        seguidos = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (linha == 4'b1110) seguidos++;
            else seguidos = 0;
            if (seguidos == 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("rdeb_achou", ok, 1'b1);
        reset = 1'b0;
        solta();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rdeb_linha",  linha, 4'b1110);
            check("rdeb_insere", bus.insere, 1'b0);
        end
        reset = 1'b1;
        espera(40);
        check("rdeb_pulsos", n_pulsos - base, 0);
        check("rdeb_numero", bus.numero, 4'b0000);

        $display("%0d/%0d checks passed", n_ok, n_tot);
        $finish;
    end

endmodule
